// File: rtl/univ_shift_reg_seq.sv
// univ_shift_reg_seq
//   Parametrised universal shift register with a built-in shift sequencer.
//   Supports hold, shift right/left, parallel load, rotate right/left,
//   arithmetic shift right and bit reverse. A START command runs a shift
//   mode automatically for CNT edges and reports BUSY and DONE.
//
// Parameters
//   WIDTH  register width in bits (>= 2)
//   CNT_W  width of the shift-count input
//
// Ports
//   CP     in   clock, rising edge
//   CR_    in   asynchronous active-low reset
//   EN     in   single-step enable (IDLE only)
//   MODE   in   operation select
//   Sr     in   serial in, enters MSB on shift right
//   Sl     in   serial in, enters LSB on shift left
//   D      in   parallel load data
//   START  in   begin auto-run of MODE for CNT shifts (IDLE only)
//   CNT    in   auto-run shift count
//   ABORT  in   stop auto-run immediately
//   Q      out  register contents
//   SO_R   out  Q[0], the bit leaving on the next right shift
//   SO_L   out  Q[WIDTH-1], the bit leaving on the next left shift
//   BUSY   out  auto-run in progress (registered)
//   DONE   out  one-cycle pulse when an auto-run finishes (registered)
module univ_shift_reg_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CP,
  input  logic             CR_,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic             Sr,
  input  logic             Sl,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] CNT,
  input  logic             ABORT,
  output logic [WIDTH-1:0] Q,
  output logic             SO_R,
  output logic             SO_L,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_LOAD = 3'b011,
    OP_ROR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_ASR  = 3'b110,
    OP_REV  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state;
  op_e              run_op;
  logic [CNT_W-1:0] remaining;

  op_e              mode_op;
  op_e              active_op;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] q_rev;

  function automatic logic is_shift(input op_e op);
    return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
           (op == OP_ROL) || (op == OP_ASR);
  endfunction

  assign mode_op = op_e'(MODE);

  // While running, the mode latched at START drives the datapath so that
  // MODE changes on the port cannot disturb an auto-run in flight.
  assign active_op = (state == ST_RUN) ? run_op : mode_op;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rev
    assign q_rev[i] = Q[WIDTH-1-i];
  end

  always_comb begin
    q_next = Q;
    case (active_op)
      OP_HOLD: q_next = Q;
      OP_SHR:  q_next = {Sr, Q[WIDTH-1:1]};
      OP_SHL:  q_next = {Q[WIDTH-2:0], Sl};
      OP_LOAD: q_next = D;
      OP_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
      OP_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
      OP_ASR:  q_next = {Q[WIDTH-1], Q[WIDTH-1:1]};
      OP_REV:  q_next = q_rev;
      default: q_next = Q;
    endcase
  end

  assign SO_R = Q[0];
  assign SO_L = Q[WIDTH-1];

  // The first shift of an auto-run happens on the START edge itself, so
  // `remaining` counts the shifts still owed after that edge. A START that
  // arrives on the run's final edge lands in ST_RUN and is therefore ignored.
  always_ff @(posedge CP or negedge CR_) begin
    if (!CR_) begin
      state     <= ST_IDLE;
      run_op    <= OP_HOLD;
      remaining <= '0;
      Q         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (is_shift(mode_op) && (CNT != '0)) begin
              Q         <= q_next;
              run_op    <= mode_op;
              remaining <= CNT - CNT_ONE;
              if (CNT == CNT_ONE) begin
                DONE <= 1'b1;
              end else begin
                state <= ST_RUN;
                BUSY  <= 1'b1;
              end
            end else begin
              DONE <= 1'b1;
            end
          end else if (EN) begin
            Q <= q_next;
          end
        end
        ST_RUN: begin
          if (ABORT) begin
            state     <= ST_IDLE;
            BUSY      <= 1'b0;
            remaining <= '0;
          end else begin
            Q         <= q_next;
            remaining <= remaining - CNT_ONE;
            if (remaining == CNT_ONE) begin
              state <= ST_IDLE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg_seq.sv
// Scoreboard bench for univ_shift_reg_seq: stimulus pushes the expected
// post-edge state into a queue, a monitor pops and compares after each edge.
module tb_univ_shift_reg_seq;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          CP;
  logic          CR_;
  logic          EN;
  logic [2:0]    MODE;
  logic          Sr;
  logic          Sl;
  logic [W-1:0]  D;
  logic          START;
  logic [CW-1:0] CNT;
  logic          ABORT;
  logic [W-1:0]  Q;
  logic          SO_R;
  logic          SO_L;
  logic          BUSY;
  logic          DONE;

  univ_shift_reg_seq #(.WIDTH(W), .CNT_W(CW)) dut (
    .CP(CP), .CR_(CR_), .EN(EN), .MODE(MODE), .Sr(Sr), .Sl(Sl), .D(D),
    .START(START), .CNT(CNT), .ABORT(ABORT), .Q(Q), .SO_R(SO_R),
    .SO_L(SO_L), .BUSY(BUSY), .DONE(DONE)
  );

  initial begin
    CP = 1'b0;
    forever #5 CP = ~CP;
  end

  typedef struct {
    int q;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: register value, shifts still owed, latched mode.
  int m_q    = 0;
  int m_left = 0;
  int m_mode = 0;
  bit m_done = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int apply_op(input int m, input int q, input bit sr,
                                  input bit sl, input int d);
    int msb  = 1 << (W - 1);
    int mask = (1 << W) - 1;
    int r    = q;
    case (m)
      1: r = (q >> 1) | (sr ? msb : 0);
      2: r = ((q << 1) & mask) | int'(sl);
      3: r = d & mask;
      4: r = (q >> 1) | (((q & 1) != 0) ? msb : 0);
      5: r = ((q << 1) & mask) | (((q & msb) != 0) ? 1 : 0);
      6: r = (q >> 1) | (q & msb);
      7: begin
        r = 0;
        for (int i = 0; i < W; i++)
          if ((q & (1 << i)) != 0) r |= 1 << (W - 1 - i);
      end
      default: r = q;
    endcase
    return r;
  endfunction

  function automatic bit is_shift_mode(input int m);
    return (m == 1) || (m == 2) || (m == 4) || (m == 5) || (m == 6);
  endfunction

  task automatic step(input bit en, input int mode, input bit sr, input bit sl,
                      input int d, input bit start, input int cnt, input bit abort);
    exp_t e;
    @(negedge CP);
    EN    = en;
    MODE  = mode[2:0];
    Sr    = sr;
    Sl    = sl;
    D     = d[W-1:0];
    START = start;
    CNT   = cnt[CW-1:0];
    ABORT = abort;
    if (m_left > 0) begin
      if (abort) begin
        m_left = 0;
        m_done = 0;
      end else begin
        m_q    = apply_op(m_mode, m_q, sr, sl, d);
        m_left = m_left - 1;
        m_done = (m_left == 0);
      end
    end else if (start) begin
      if (is_shift_mode(mode) && cnt > 0) begin
        m_q    = apply_op(mode, m_q, sr, sl, d);
        m_mode = mode;
        m_left = cnt - 1;
        m_done = (cnt == 1);
      end else begin
        m_done = 1;
      end
    end else begin
      if (en) m_q = apply_op(mode, m_q, sr, sl, d);
      m_done = 0;
    end
    e.q    = m_q;
    e.busy = (m_left > 0);
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Pin a few spec-stated values directly, after the monitor has run.
  task automatic chk(input string name, input int q, input bit busy, input bit done);
    @(posedge CP);
    #2;
    cmp({name, "_q"}, int'(Q), q);
    cmp({name, "_busy"}, int'(BUSY), int'(busy));
    cmp({name, "_done"}, int'(DONE), int'(done));
  endtask

  task automatic do_reset(input string tag);
    @(negedge CP);
    CR_   = 1'b0;
    EN    = 1'b0;
    START = 1'b0;
    ABORT = 1'b0;
    #1;
    cmp({tag, "_async_q"}, int'(Q), 0);
    cmp({tag, "_async_busy"}, int'(BUSY), 0);
    cmp({tag, "_async_done"}, int'(DONE), 0);
    m_q = 0; m_left = 0; m_mode = 0; m_done = 0;
    @(posedge CP);
    #1;
    cmp({tag, "_held_q"}, int'(Q), 0);
    @(negedge CP);
    CR_ = 1'b1;
  endtask

  // Monitor: one expected record per clocked step.
  initial begin
    exp_t e;
    forever begin
      @(posedge CP);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("mon_q", int'(Q), e.q);
        cmp("mon_so_r", int'(SO_R), e.q & 1);
        cmp("mon_so_l", int'(SO_L), (e.q >> (W - 1)) & 1);
        cmp("mon_busy", int'(BUSY), int'(e.busy));
        cmp("mon_done", int'(DONE), int'(e.done));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    CR_ = 1'b0; EN = 0; MODE = 0; Sr = 0; Sl = 0; D = '0;
    START = 0; CNT = '0; ABORT = 0;
    do_reset("por");

    // T1: reset in the middle of an auto-run
    step(1, 3, 0, 0, 'hA5, 0, 0, 0);
    step(0, 4, 0, 0, 0, 1, 5, 0);
    idle();
    do_reset("T1");

    // T2: single-step operations
    step(1, 3, 0, 0, 'hA5, 0, 0, 0); chk("T2_load", 'hA5, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);    chk("T2_shr", 'hD2, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0, 0);    chk("T2_shl", 'hA4, 0, 0);
    step(1, 7, 0, 0, 0, 0, 0, 0);    chk("T2_rev", 'h25, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 3, 1, 1, 'hFF, 0, 0, 0); chk("T2_hold", 'h25, 0, 0);
    end

    // T3: auto ror, with a START on the final edge that must be ignored
    step(1, 3, 0, 0, 'h81, 0, 0, 0);
    step(0, 4, 0, 0, 0, 1, 3, 0);    chk("T3_e1", 'hC0, 1, 0);
    idle();                          chk("T3_e2", 'h60, 1, 0);
    step(0, 2, 0, 1, 0, 1, 2, 0);    chk("T3_e3", 'h30, 0, 1);
    idle();                          chk("T3_after", 'h30, 0, 0);

    // T4: auto asr, port activity during the run has no effect
    step(1, 3, 0, 0, 'h90, 0, 0, 0);
    step(0, 6, 0, 0, 0, 1, 2, 0);    chk("T4_e1", 'hC8, 1, 0);
    step(1, 3, 0, 0, 'hFF, 0, 0, 0); chk("T4_e2", 'hE4, 0, 1);
    idle();

    // T5: corner cases
    step(1, 3, 0, 0, 'h3C, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 1, 0);    chk("T5_cnt1", 'h1E, 0, 1);
    step(0, 1, 1, 0, 0, 1, 0, 0);    chk("T5_cnt0", 'h1E, 0, 1);
    step(1, 3, 0, 0, 'hFF, 1, 5, 0); chk("T5_load_start", 'h1E, 0, 1);
    step(0, 0, 0, 0, 0, 1, 4, 0);    chk("T5_hold_start", 'h1E, 0, 1);
    idle();                          chk("T5_clear", 'h1E, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);    chk("T5_abort_idle", 'h1E, 0, 0);

    // T6: abort after 4 of 10 shifts, then reset mid-run
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 1, 0, 1, 10, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 1);    chk("T6_abort", 'h0F, 0, 0);
    idle();                          chk("T6_no_done", 'h0F, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 2, 0, 1, 0, 1, 10, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    do_reset("T6_rst");
    idle();

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             int'($urandom_range(0, 255)),
             ($urandom_range(0, 4) == 0), int'($urandom_range(0, 15)),
             ($urandom_range(0, 11) == 0));
      end
    end

    idle();
    idle();
    @(posedge CP);
    #3;
    cmp("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
